counter_sequencer: RTL

- Control wrapper around a WIDTH-bit binary counter.
- Sequences the counter through start, run, pause, terminal-count and optional auto-reload.
- Reports status to a host FSM.
- Sits between a control host and the ripple/binary counter datapath. The count register is internal; its value is exported on count.

---
 rtl/counter_sequencer.sv | 77 +++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: start/run/pause/terminal-count/auto-reload control around a WIDTH-bit counter
module counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             dir,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, term_q, term_d, start_val, end_val;
  logic dir_q, dir_d, reload_q, reload_d, done_q, done_d, at_end, active;
  assign start_val = dir_q ? term_q : '0;
  assign end_val = dir_q ? '0 : term_q;
  assign at_end = count_q == end_val;
  // leaving PAUSE behaves exactly like a RUN edge, so the release edge also steps
  assign active = state_q == RUN || (state_q == PAUSE && !pause);
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d = term_q;
    dir_d = dir_q;
    reload_d = reload_q;
    done_d = 1'b0;
    if (abort) begin
      state_d = IDLE;
      count_d = '0;
    end else if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = RUN;
      term_d = term;
      dir_d = dir;
      reload_d = reload_en;
      count_d = dir ? term : '0;
    end else if (active) begin
      if (at_end) begin
        done_d = 1'b1;
        state_d = reload_q ? RUN : DONE;
        count_d = reload_q ? start_val : count_q;
      end else if (pause) begin
        state_d = PAUSE;
      end else begin
        state_d = RUN;
        count_d = dir_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      term_q <= '0;
      dir_q <= 1'b0;
      reload_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q <= term_d;
      dir_q <= dir_d;
      reload_q <= reload_d;
      done_q <= done_d;
    end
  end
  assign count = count_q;
  assign state = state_q;
  assign busy = state_q == RUN || state_q == PAUSE;
  assign done = done_q;
endmodule
